// File: rtl/pic_pkg.sv
// pic_pkg: loader FSM states, default geometry and frame width
package pic_pkg;
    localparam int WORD_W_DEF = 12;
    localparam int NUM_WORDS_DEF = 11;
    localparam int FRAME_W = 2 * WORD_W_DEF;
    typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, STROBE, GAP, DONE} state_t;
endpackage

// File: rtl/pic_frame_shifter.sv
// pic_frame_shifter: word plus one-hot address frame, shifted LSB first with bit counter
module pic_frame_shifter import pic_pkg::*; #(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        idx,
    output logic              nxt,
    output logic              last
);
    localparam int FW = 2 * WORD_W;
    localparam int CW = $clog2(FW);
    logic [FW-1:0] q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
            cnt <= '0;
        end else if (load) begin
            q <= {{WORD_W{1'b0}}, word} | (FW'(1) << (WORD_W + int'(idx)));
            cnt <= '0;
        end else if (shift) begin
            q <= q >> 1;
            cnt <= cnt + 1'b1;
        end
    end
    assign nxt = q[1];
    assign last = cnt == CW'(FW - 1);
endmodule

// File: rtl/pic_prog_loader.sv
// pic_prog_loader: serial program loader FSM; PIC_LOADER_AUTOSTART_EN releases the CPU on completion
module pic_prog_loader import pic_pkg::*; #(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    input  logic              run_req,
    output logic              prog_sclk,
    output logic              prog_data,
    output logic              prog_strobe,
    output logic              cpu_run,
    output logic              busy,
    output logic [3:0]        word_idx
);
`ifdef PIC_LOADER_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    state_t state;
    logic hold, nxt, last;
    pic_frame_shifter #(.WORD_W(WORD_W)) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (state == WAIT_WORD && word_valid),
        .shift (state == SHIFT_HI && !last),
        .word  (word_data),
        .idx   (word_idx),
        .nxt   (nxt),
        .last  (last)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold <= 1'b0;
            word_ready <= 1'b0;
            prog_sclk <= 1'b0;
            prog_data <= 1'b0;
            prog_strobe <= 1'b0;
            cpu_run <= 1'b0;
            busy <= 1'b0;
            word_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= WAIT_WORD;
                        word_ready <= 1'b1;
                        busy <= 1'b1;
                        cpu_run <= 1'b0;
                        word_idx <= '0;
                    end else if (state == DONE && run_req && !AUTO) begin
                        cpu_run <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        state <= SHIFT_LO;
                        word_ready <= 1'b0;
                        prog_data <= word_data[0];
                    end
                end
                SHIFT_LO: begin
                    state <= SHIFT_HI;
                    prog_sclk <= 1'b1;
                end
                SHIFT_HI: begin
                    prog_sclk <= 1'b0;
                    state <= last ? STROBE : SHIFT_LO;
                    prog_strobe <= last;
                    prog_data <= last ? 1'b0 : nxt;
                    hold <= 1'b0;
                end
                STROBE: begin
                    hold <= ~hold;
                    if (hold) begin
                        state <= GAP;
                        prog_strobe <= 1'b0;
                    end
                end
                GAP: begin
                    hold <= ~hold;
                    if (hold) begin
                        if (word_idx == 4'(NUM_WORDS - 1)) begin
                            state <= DONE;
                            busy <= 1'b0;
                            cpu_run <= AUTO;
                        end else begin
                            state <= WAIT_WORD;
                            word_ready <= 1'b1;
                            word_idx <= word_idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
